// File: rtl/id_stage_pipe_pkg.sv
// Shared decode definitions for the ID stage: opcode/func constants, pcsource encodings,
// ALU control codes and the combinational control unit used by id_stage_pipe.
package id_stage_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_LUI = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } aluc_t;

  typedef struct packed {
    logic  wreg, m2reg, wmem, aluimm, shift, sext, regrt;
    logic  use_rs, use_rt, beq, bne, jmp, jal, jr;
    aluc_t aluc;
  } ctrl_t;

  // Unknown opcodes/funcs decode to an inert bubble-like instruction.
  function automatic ctrl_t control_unit(input logic [5:0] op, input logic [5:0] func);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.use_rs = 1'b1;
        c.use_rt = 1'b1;
        c.wreg   = 1'b1;
        case (func)
          F_ADD:   c.aluc = ALU_ADD;
          F_SUB:   c.aluc = ALU_SUB;
          F_AND:   c.aluc = ALU_AND;
          F_OR:    c.aluc = ALU_OR;
          F_XOR:   c.aluc = ALU_XOR;
          F_SLL:   begin c.aluc = ALU_SLL; c.shift = 1'b1; end
          F_SRL:   begin c.aluc = ALU_SRL; c.shift = 1'b1; end
          F_JR:    begin c.wreg = 1'b0; c.jr = 1'b1; end
          default: c.wreg = 1'b0;
        endcase
      end
      OP_ADDI: begin c.wreg = 1'b1; c.aluimm = 1'b1; c.sext = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1; end
      OP_ANDI: begin c.wreg = 1'b1; c.aluimm = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1; c.aluc = ALU_AND; end
      OP_ORI:  begin c.wreg = 1'b1; c.aluimm = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1; c.aluc = ALU_OR; end
      OP_XORI: begin c.wreg = 1'b1; c.aluimm = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1; c.aluc = ALU_XOR; end
      OP_LUI:  begin c.wreg = 1'b1; c.aluimm = 1'b1; c.regrt = 1'b1; c.aluc = ALU_LUI; end
      OP_LW:   begin c.wreg = 1'b1; c.m2reg = 1'b1; c.aluimm = 1'b1; c.sext = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1; end
      OP_SW:   begin c.wmem = 1'b1; c.aluimm = 1'b1; c.sext = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1; end
      OP_BEQ:  begin c.beq = 1'b1; c.sext = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1; c.aluc = ALU_SUB; end
      OP_BNE:  begin c.bne = 1'b1; c.sext = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1; c.aluc = ALU_SUB; end
      OP_J:    c.jmp = 1'b1;
      OP_JAL:  begin c.jal = 1'b1; c.wreg = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_pipe_regfile_bypass.sv
// Register file with two read ports and one write port; a same-cycle write is visible
// on the read ports (write-through) and register 0 always reads zero.
module regfile_bypass
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              we,
  input  logic [REG_AW-1:0] wn,
  input  logic [XLEN-1:0]   wd,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2
);

  localparam int unsigned NREG = 2 ** REG_AW;

  logic [XLEN-1:0] regs_r [NREG];

  assign rd1 = (ra1 == '0) ? '0 : ((we && (wn == ra1)) ? wd : regs_r[ra1]);
  assign rd2 = (ra2 == '0) ? '0 : ((we && (wn == ra2)) ? wd : regs_r[ra2]);

  // Storage: async clear, writes to register 0 dropped.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) regs_r[i] <= '0;
    end else if (we && (wn != '0)) begin
      regs_r[wn] <= wd;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: control decode, bypassed operand read, EX/MEM forwarding, load-use and
// no-forwarding stalls, branch/jump resolution in ID, and the ID/EX pipeline register.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              d_valid,
  input  logic [XLEN-1:0]   d_pc4,
  input  logic [31:0]       d_inst,
  output logic              id_ready,
  output logic              if_flush,
  output logic [1:0]        pcsource,
  output logic [XLEN-1:0]   bpc,
  output logic [XLEN-1:0]   jpc,
  output logic [XLEN-1:0]   jrpc,
  input  logic              ex_wreg,
  input  logic              ex_m2reg,
  input  logic [REG_AW-1:0] ex_rn,
  input  logic [XLEN-1:0]   ex_alu,
  input  logic              mem_wreg,
  input  logic [REG_AW-1:0] mem_rn,
  input  logic [XLEN-1:0]   mem_wd,
  input  logic              wb_wreg,
  input  logic [REG_AW-1:0] wb_rn,
  input  logic [XLEN-1:0]   wdi,
  output logic              e_valid,
  output logic              e_wreg,
  output logic              e_m2reg,
  output logic              e_wmem,
  output logic              e_aluimm,
  output logic              e_shift,
  output logic [2:0]        e_aluc,
  output logic [REG_AW-1:0] e_rn,
  output logic [XLEN-1:0]   e_a,
  output logic [XLEN-1:0]   e_b,
  output logic [XLEN-1:0]   e_imm
);

  logic [5:0]        op_s, func_s;
  logic [15:0]       imm16_s;
  logic [REG_AW-1:0] rs_s, rt_s, rd_s, rn_s;
  ctrl_t             ctrl_s;
  logic [XLEN-1:0]   rf_a_s, rf_b_s, fwd_a_s, fwd_b_s, imm_ext_s;
  logic              ex_rs_s, ex_rt_s, mem_rs_s, mem_rt_s;
  logic              load_use_s, raw_s, stall_s, accept_s, rsrtequ_s;
  logic [1:0]        pcsel_s;

  assign op_s    = d_inst[31:26];
  assign func_s  = d_inst[25:20];
  assign imm16_s = d_inst[25:10];
  assign rd_s    = REG_AW'(d_inst[14:10]);
  assign rs_s    = REG_AW'(d_inst[9:5]);
  assign rt_s    = REG_AW'(d_inst[4:0]);
  assign ctrl_s  = control_unit(op_s, func_s);

  regfile_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rf (
    .clk(clk), .clrn(clrn), .we(wb_wreg), .wn(wb_rn), .wd(wdi),
    .ra1(rs_s), .ra2(rt_s), .rd1(rf_a_s), .rd2(rf_b_s)
  );

  // RAW matches against in-flight writers; register 0 never matches.
  assign ex_rs_s  = ex_wreg  && (ex_rn  == rs_s) && (rs_s != '0);
  assign ex_rt_s  = ex_wreg  && (ex_rn  == rt_s) && (rt_s != '0);
  assign mem_rs_s = mem_wreg && (mem_rn == rs_s) && (rs_s != '0);
  assign mem_rt_s = mem_wreg && (mem_rn == rt_s) && (rt_s != '0);

  // Operand select: EX ALU result, then MEM write-back value, then register file.
  always_comb begin
    if (FWD_EN && ex_rs_s && !ex_m2reg) fwd_a_s = ex_alu;
    else if (FWD_EN && mem_rs_s)        fwd_a_s = mem_wd;
    else                                fwd_a_s = rf_a_s;
    if (FWD_EN && ex_rt_s && !ex_m2reg) fwd_b_s = ex_alu;
    else if (FWD_EN && mem_rt_s)        fwd_b_s = mem_wd;
    else                                fwd_b_s = rf_b_s;
  end

  assign load_use_s = ex_m2reg && ((ctrl_s.use_rs && ex_rs_s) || (ctrl_s.use_rt && ex_rt_s));
  assign raw_s      = (ctrl_s.use_rs && (ex_rs_s || mem_rs_s)) ||
                      (ctrl_s.use_rt && (ex_rt_s || mem_rt_s));
  assign stall_s    = d_valid && (load_use_s || (!FWD_EN && raw_s));
  assign accept_s   = d_valid && !stall_s;
  assign id_ready   = !stall_s;
  assign rsrtequ_s  = (fwd_a_s == fwd_b_s);

  // Redirect only for an accepted instruction; stalls and bubbles stay sequential.
  always_comb begin
    pcsel_s = PC_SEQ;
    if (!accept_s)                     pcsel_s = PC_SEQ;
    else if (ctrl_s.jr)                pcsel_s = PC_JR;
    else if (ctrl_s.jmp || ctrl_s.jal) pcsel_s = PC_J;
    else if ((ctrl_s.beq && rsrtequ_s) || (ctrl_s.bne && !rsrtequ_s)) pcsel_s = PC_BR;
    else                               pcsel_s = PC_SEQ;
  end

  assign pcsource  = pcsel_s;
  assign if_flush  = (pcsel_s != PC_SEQ);
  assign imm_ext_s = ctrl_s.sext ? {{(XLEN-16){imm16_s[15]}}, imm16_s} : {{(XLEN-16){1'b0}}, imm16_s};
  assign bpc       = d_pc4 + {{(XLEN-18){imm16_s[15]}}, imm16_s, 2'b00};
  assign jpc       = {d_pc4[XLEN-1:28], d_inst[25:0], 2'b00};
  assign jrpc      = fwd_a_s;

  // Destination: jal links into the top register, I-types write rt, R-types write rd.
  always_comb begin
    if (ctrl_s.jal)        rn_s = '1;
    else if (ctrl_s.regrt) rn_s = rt_s;
    else                   rn_s = rd_s;
  end

  // ID/EX register: loads the decoded instruction when accepted, otherwise an all-zero bubble.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e_valid <= 1'b0; e_wreg <= 1'b0; e_m2reg <= 1'b0; e_wmem <= 1'b0;
      e_aluimm <= 1'b0; e_shift <= 1'b0; e_aluc <= 3'd0; e_rn <= '0;
      e_a <= '0; e_b <= '0; e_imm <= '0;
    end else if (accept_s) begin
      e_valid <= 1'b1; e_wreg <= ctrl_s.wreg; e_m2reg <= ctrl_s.m2reg; e_wmem <= ctrl_s.wmem;
      e_aluimm <= ctrl_s.aluimm; e_shift <= ctrl_s.shift; e_aluc <= ctrl_s.aluc; e_rn <= rn_s;
      e_a <= fwd_a_s; e_b <= fwd_b_s; e_imm <= imm_ext_s;
    end else begin
      e_valid <= 1'b0; e_wreg <= 1'b0; e_m2reg <= 1'b0; e_wmem <= 1'b0;
      e_aluimm <= 1'b0; e_shift <= 1'b0; e_aluc <= 3'd0; e_rn <= '0;
      e_a <= '0; e_b <= '0; e_imm <= '0;
    end
  end

endmodule
